// File: rtl/imem_program_loader.sv
// -----------------------------------------------------------------------------
// imem_program_loader
//
// Loads a program into the IF-stage instruction memory from a byte stream
// (debug UART RX FIFO). A load clears the memory, packs four bytes
// big-endian into each instruction word and writes it with a one-cycle
// strobe. The load stops when the HALT word has been written. It reports
// done, overflow and (optionally) inter-byte timeout to the debug unit.
//
// Optional feature: define LOADER_TIMEOUT_EN to enable the inter-byte timeout.
// The timeout length is TIMEOUT_CYCLES. Without the macro, LOAD waits for
// bytes indefinitely.
//
// Ports:
//   i_clk          clock
//   i_reset        synchronous, active-high reset
//   i_load_start   one-cycle pulse: begin (or restart) a load
//   i_rx_valid     byte available on i_rx_data
//   i_rx_data      received byte
//   i_mem_full     instruction memory full flag
//   o_rx_ack       byte consumed this cycle (combinational)
//   o_mem_clear    one-cycle clear pulse to instruction memory
//   o_inst_write   one-cycle write strobe
//   o_instruction  assembled word, valid while o_inst_write=1, held otherwise
//   o_busy         high in CLEAR and LOAD
//   o_load_done    sticky: HALT word written
//   o_load_error   sticky: overflow or timeout
//   o_word_count   words written this load, saturates at MEM_SIZE_WORDS
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | after reset, waiting for i_load_start
// CLEAR  | one cycle, instruction memory clear pulse
// LOAD   | accepting bytes, writing each complete word
// DONE   | HALT word written, waiting for a restart
// ERROR  | overflow or timeout, waiting for a restart
// -----------------------------------------------------------------------------
module imem_program_loader #(
    parameter int                         WORD_WIDTH_BITS = 32,
    parameter int                         MEM_SIZE_WORDS  = 10,
    parameter logic [WORD_WIDTH_BITS-1:0] HALT_INSTR      = 32'hFFFF_FFFF,
    parameter int                         TIMEOUT_CYCLES  = 1000000
) (
    input  logic                                  i_clk,
    input  logic                                  i_reset,
    input  logic                                  i_load_start,
    input  logic                                  i_rx_valid,
    input  logic [7:0]                            i_rx_data,
    input  logic                                  i_mem_full,
    output logic                                  o_rx_ack,
    output logic                                  o_mem_clear,
    output logic                                  o_inst_write,
    output logic [WORD_WIDTH_BITS-1:0]            o_instruction,
    output logic                                  o_busy,
    output logic                                  o_load_done,
    output logic                                  o_load_error,
    output logic [$clog2(MEM_SIZE_WORDS+1)-1:0]   o_word_count
);

    localparam int                 COUNT_W   = $clog2(MEM_SIZE_WORDS + 1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MEM_SIZE_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                     state;
    logic [1:0]                 byte_cnt;
    logic [WORD_WIDTH_BITS-1:0] asm_word;
    logic [WORD_WIDTH_BITS-1:0] next_word;
    logic                       byte_accept;

`ifdef LOADER_TIMEOUT_EN
    localparam int                TMO_W      = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0]  TMO_RELOAD = TMO_W'(TIMEOUT_CYCLES - 1);
    // Down-counter: reloaded on LOAD entry and on every accepted byte; a
    // byte-less cycle with the counter at zero is the timeout.
    logic [TMO_W-1:0] tmo_cnt;
`else
    logic unused_timeout_param;
    assign unused_timeout_param = (TIMEOUT_CYCLES == 0);
`endif

    // Shift-in view of the word including the byte on the bus; on the
    // fourth byte this is the complete big-endian word.
    assign next_word   = {asm_word[WORD_WIDTH_BITS-9:0], i_rx_data};
    assign byte_accept = (state == S_LOAD) && i_rx_valid;
    assign o_rx_ack    = byte_accept;
    assign o_mem_clear = (state == S_CLEAR);
    assign o_busy      = (state == S_CLEAR) || (state == S_LOAD);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= S_IDLE;
            byte_cnt      <= 2'd0;
            asm_word      <= '0;
            o_inst_write  <= 1'b0;
            o_instruction <= '0;
            o_load_done   <= 1'b0;
            o_load_error  <= 1'b0;
            o_word_count  <= '0;
`ifdef LOADER_TIMEOUT_EN
            tmo_cnt       <= TMO_RELOAD;
`endif
        end else begin
            o_inst_write <= 1'b0;
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (i_load_start) begin
                        state        <= S_CLEAR;
                        byte_cnt     <= 2'd0;
                        asm_word     <= '0;
                        o_load_done  <= 1'b0;
                        o_load_error <= 1'b0;
                        o_word_count <= '0;
                    end
                end

                S_CLEAR: begin
                    state <= S_LOAD;
`ifdef LOADER_TIMEOUT_EN
                    tmo_cnt <= TMO_RELOAD;
`endif
                end

                S_LOAD: begin
                    // Restart wins over everything, including a fourth byte
                    // arriving in the same cycle; that word is dropped.
                    if (i_load_start) begin
                        state        <= S_CLEAR;
                        byte_cnt     <= 2'd0;
                        asm_word     <= '0;
                        o_load_done  <= 1'b0;
                        o_load_error <= 1'b0;
                        o_word_count <= '0;
                    end else if (i_rx_valid) begin
                        byte_cnt <= byte_cnt + 2'd1;
                        asm_word <= next_word;
`ifdef LOADER_TIMEOUT_EN
                        tmo_cnt  <= TMO_RELOAD;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (i_mem_full) begin
                                state        <= S_ERROR;
                                o_load_error <= 1'b1;
                            end else begin
                                o_inst_write  <= 1'b1;
                                o_instruction <= next_word;
                                if (o_word_count != COUNT_MAX) begin
                                    o_word_count <= o_word_count + 1'b1;
                                end
                                if (next_word == HALT_INSTR) begin
                                    state       <= S_DONE;
                                    o_load_done <= 1'b1;
                                end
                            end
                        end
                    end else begin
`ifdef LOADER_TIMEOUT_EN
                        if (tmo_cnt == '0) begin
                            state        <= S_ERROR;
                            o_load_error <= 1'b1;
                        end else begin
                            tmo_cnt <= tmo_cnt - 1'b1;
                        end
`endif
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_program_loader.sv
module tb_imem_program_loader;

    logic        clk;
    logic        reset;
    logic        load_start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        mem_full;
    logic        rx_ack;
    logic        mem_clear;
    logic        inst_write;
    logic [31:0] instruction;
    logic        busy;
    logic        load_done;
    logic        load_error;
    logic [3:0]  word_count;

    int total = 0;
    int bad   = 0;
    logic ack_s;

    imem_program_loader #(
        .WORD_WIDTH_BITS (32),
        .MEM_SIZE_WORDS  (10),
        .HALT_INSTR      (32'hFFFF_FFFF),
        .TIMEOUT_CYCLES  (16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_load_start  (load_start),
        .i_rx_valid    (rx_valid),
        .i_rx_data     (rx_data),
        .i_mem_full    (mem_full),
        .o_rx_ack      (rx_ack),
        .o_mem_clear   (mem_clear),
        .o_inst_write  (inst_write),
        .o_instruction (instruction),
        .o_busy        (busy),
        .o_load_done   (load_done),
        .o_load_error  (load_error),
        .o_word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One record = inputs applied for one cycle, o_rx_ack expected during
    // that cycle, registered outputs expected in the following cycle.
    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  d;
        logic        f;
        logic        ack;
        logic        wr;
        logic [31:0] ins;
        logic        clr;
        logic        bsy;
        logic        done;
        logic        err;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d, input logic f,
                                input logic ack, input logic wr, input logic [31:0] ins,
                                input logic clr, input logic bsy, input logic done,
                                input logic err, input logic [3:0] cnt);
        vec_t r;
        r.st = st; r.v = v; r.d = d; r.f = f; r.ack = ack; r.wr = wr; r.ins = ins;
        r.clr = clr; r.bsy = bsy; r.done = done; r.err = err; r.cnt = cnt;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic v, input logic [7:0] d, input logic f);
        load_start = st;
        rx_valid   = v;
        rx_data    = d;
        mem_full   = f;
        #2;
        ack_s = rx_ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic wr, input logic [31:0] ins,
                              input logic clr, input logic bsy, input logic done,
                              input logic err, input logic [3:0] cnt);
        chk({tag, ".write"}, {31'd0, inst_write}, {31'd0, wr});
        chk({tag, ".instr"}, instruction, ins);
        chk({tag, ".clear"}, {31'd0, mem_clear}, {31'd0, clr});
        chk({tag, ".busy"},  {31'd0, busy}, {31'd0, bsy});
        chk({tag, ".done"},  {31'd0, load_done}, {31'd0, done});
        chk({tag, ".error"}, {31'd0, load_error}, {31'd0, err});
        chk({tag, ".count"}, {28'd0, word_count}, {28'd0, cnt});
    endtask

    // Sends one word MSB first; no write may appear before the fourth byte.
    task automatic send_word(input string tag, input logic [31:0] w, input logic f);
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 1'b1, w[31-8*b -: 8], f);
            chk($sformatf("%s.ack%0d", tag, b), {31'd0, ack_s}, 32'd1);
            if (b < 3) chk($sformatf("%s.partial%0d", tag, b), {31'd0, inst_write}, 32'd0);
        end
    endtask

    initial begin
        reset = 1'b1; load_start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; mem_full = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("reset.ack", {31'd0, rx_ack}, 32'd0);
        reset = 1'b0;

        // Basic load with HALT, then restart with aborts.
        //           st v  d      f  ack wr ins           clr bsy dn er cnt
        tab.push_back(mk(1,1,8'h99,0, 0, 0, 32'h0,        1,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h99,0, 0, 0, 32'h0,        0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h12,0, 1, 0, 32'h0,        0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h34,0, 1, 0, 32'h0,        0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h56,0, 1, 0, 32'h0,        0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h78,0, 1, 1, 32'h12345678, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'hFF,0, 1, 0, 32'h12345678, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'hFF,0, 1, 0, 32'h12345678, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'hFF,0, 1, 0, 32'h12345678, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'hFF,0, 1, 1, 32'hFFFFFFFF, 0,  0,  1, 0, 2));
        tab.push_back(mk(0,1,8'h11,0, 0, 0, 32'hFFFFFFFF, 0,  0,  1, 0, 2));
        tab.push_back(mk(1,0,8'h00,0, 0, 0, 32'hFFFFFFFF, 1,  1,  0, 0, 0));
        tab.push_back(mk(0,0,8'h00,0, 0, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hA1,0, 1, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hA2,0, 1, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(1,0,8'h00,0, 0, 0, 32'hFFFFFFFF, 1,  1,  0, 0, 0));
        tab.push_back(mk(0,0,8'h00,0, 0, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hAA,0, 1, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hBB,0, 1, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hCC,0, 1, 0, 32'hFFFFFFFF, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'hDD,0, 1, 1, 32'hAABBCCDD, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'h01,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'h02,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 1));
        tab.push_back(mk(0,1,8'h03,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 1));
        tab.push_back(mk(1,1,8'h04,0, 1, 0, 32'hAABBCCDD, 1,  1,  0, 0, 0));
        tab.push_back(mk(0,0,8'h00,0, 0, 0, 32'hAABBCCDD, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,0,8'h00,0, 0, 0, 32'hAABBCCDD, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h05,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h06,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h07,0, 1, 0, 32'hAABBCCDD, 0,  1,  0, 0, 0));
        tab.push_back(mk(0,1,8'h08,0, 1, 1, 32'h05060708, 0,  1,  0, 0, 1));

        foreach (tab[i]) begin
            cyc(tab[i].st, tab[i].v, tab[i].d, tab[i].f);
            chk($sformatf("vec%0d.ack", i), {31'd0, ack_s}, {31'd0, tab[i].ack});
            check_outs($sformatf("vec%0d", i), tab[i].wr, tab[i].ins, tab[i].clr,
                       tab[i].bsy, tab[i].done, tab[i].err, tab[i].cnt);
        end

        // Overflow: ten words fill the memory, the eleventh sees i_mem_full.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            send_word($sformatf("ovf%0d", i), 32'h0100_0000 + i, 1'b0);
            check_outs($sformatf("ovf%0d", i), 1'b1, 32'h0100_0000 + i, 1'b0, 1'b1, 1'b0, 1'b0, 4'(i + 1));
        end
        send_word("ovf10", 32'h0200_0000, 1'b1);
        check_outs("ovf10", 1'b0, 32'h0100_0009, 1'b0, 1'b0, 1'b0, 1'b1, 4'd10);
        cyc(1'b0, 1'b1, 8'h33, 1'b1);
        chk("ovf.err_ack", {31'd0, ack_s}, 32'd0);
        chk("ovf.err_hold", {31'd0, load_error}, 32'd1);

        // Saturation: eleven words without the full flag keep the count at 10.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        check_outs("sat.start", 1'b0, 32'h0100_0009, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 11; i++) send_word($sformatf("sat%0d", i), 32'h0300_0000 + i, 1'b0);
        check_outs("sat", 1'b1, 32'h0300_000A, 1'b0, 1'b1, 1'b0, 1'b0, 4'd10);

        // Reset mid-load after three bytes of the second word.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        send_word("rst.w", 32'h0102_0304, 1'b0);
        check_outs("rst.w", 1'b1, 32'h0102_0304, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
        cyc(1'b0, 1'b1, 8'h21, 1'b0);
        cyc(1'b0, 1'b1, 8'h22, 1'b0);
        cyc(1'b0, 1'b1, 8'h23, 1'b0);
        reset = 1'b1;
        cyc(1'b0, 1'b1, 8'h24, 1'b0);
        check_outs("rst.in", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        reset = 1'b0;
        cyc(1'b0, 1'b1, 8'h24, 1'b0);
        chk("rst.idle_ack", {31'd0, ack_s}, 32'd0);
        check_outs("rst.after", 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        send_word("rst.reload", 32'h0A0B_0C0D, 1'b0);
        check_outs("rst.reload", 1'b1, 32'h0A0B_0C0D, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);

`ifdef LOADER_TIMEOUT_EN
        // One byte then silence: error on the 16th byte-less cycle.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("tmo.wait%0d", i), {31'd0, load_error}, 32'd0);
        end
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check_outs("tmo.fire", 1'b0, 32'h0A0B_0C0D, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0);

        // 15-cycle gaps between bytes never time out.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        for (int b = 0; b < 4; b++) begin
            cyc(1'b0, 1'b1, 8'hC0 + 8'(b), 1'b0);
            if (b < 3) begin
                for (int g = 0; g < 15; g++) begin
                    cyc(1'b0, 1'b0, 8'h00, 1'b0);
                    chk($sformatf("gap%0d_%0d", b, g), {31'd0, load_error}, 32'd0);
                end
            end
        end
        check_outs("gap.write", 1'b1, 32'hC0C1_C2C3, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
`else
        // Without the timeout LOAD waits indefinitely.
        cyc(1'b1, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b0, 1'b1, 8'h55, 1'b0);
        repeat (40) cyc(1'b0, 1'b0, 8'h00, 1'b0);
        check_outs("notmo", 1'b0, 32'h0A0B_0C0D, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        cyc(1'b0, 1'b1, 8'h66, 1'b0);
        cyc(1'b0, 1'b1, 8'h77, 1'b0);
        cyc(1'b0, 1'b1, 8'h88, 1'b0);
        check_outs("notmo.write", 1'b1, 32'h5566_7788, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
